// File: rtl/taint_scan_pkg.sv
// Shared encodings for the taint memory scan/clear sequencer.
package taint_scan_pkg;

    typedef enum logic [1:0] {
        OpScan      = 2'b00,
        OpClear     = 2'b01,
        OpScanClear = 2'b10,
        OpRsvd      = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StChk,
        StWr,
        StRsp
    } state_e;

endpackage

// File: rtl/taint_scan_accum.sv
// Summary accumulator for a taint sweep: nonzero-word count, lowest tainted address, OR mask.
module taint_scan_accum #(
    parameter int unsigned ABITS = 6,
    parameter int unsigned WIDTH = 8
) (
    input  logic             pos_clk,
    input  logic             pos_arst,
    input  logic             clear,
    input  logic             acc_en,
    input  logic [ABITS-1:0] addr,
    input  logic [WIDTH-1:0] data,
    output logic [ABITS:0]   count,
    output logic [ABITS-1:0] first,
    output logic             found,
    output logic [WIDTH-1:0] mask
);

    logic [ABITS:0]   count_q;
    logic [ABITS-1:0] first_q;
    logic [WIDTH-1:0] mask_q;

    always_ff @(posedge pos_clk or posedge pos_arst) begin
        if (pos_arst) begin
            count_q <= '0;
            first_q <= '0;
            mask_q  <= '0;
        end else if (clear) begin
            count_q <= '0;
            first_q <= '0;
            mask_q  <= '0;
        end else if (acc_en && data != '0) begin
            count_q <= count_q + (ABITS+1)'(1);
            // Sweep runs in ascending order, so the first hit is the lowest address.
            if (count_q == '0) begin
                first_q <= addr;
            end
            mask_q <= mask_q | data;
        end
    end

    assign count = count_q;
    assign first = first_q;
    assign found = (count_q != '0);
    assign mask  = mask_q;

endmodule

// File: rtl/taint_scan_ctrl.sv
// Sweeps a shadow taint memory through a port shared with design-side writes,
// scanning and/or clearing every word and reporting a taint summary.
module taint_scan_ctrl
    import taint_scan_pkg::*;
#(
    parameter int unsigned SIZE  = 64,
    parameter int unsigned ABITS = 6,
    parameter int unsigned WIDTH = 8
) (
    input  logic             pos_clk,
    input  logic             pos_arst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             host_wr_en,
    input  logic [ABITS-1:0] host_wr_addr,
    output logic             mem_rd_en,
    output logic [ABITS-1:0] mem_rd_addr,
    input  logic [WIDTH-1:0] mem_rd_data,
    output logic             mem_wr_en,
    output logic [ABITS-1:0] mem_wr_addr,
    output logic             busy,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ABITS:0]   rsp_count,
    output logic [ABITS-1:0] rsp_first,
    output logic             rsp_found,
    output logic [WIDTH-1:0] rsp_mask,
    output logic             rsp_err
);

    localparam logic [ABITS-1:0] LastAddr = ABITS'(SIZE - 1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [ABITS-1:0] addr_q, addr_d;
    logic             err_q, err_d;
    logic             hold_q, hold_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] chk_data;
    logic             acc_clear, acc_en;
    logic             last;

    assign last = (addr_q == LastAddr);
    // Read data is only on the bus for one cycle; a held CHK works from the captured copy.
    assign chk_data = hold_q ? data_q : mem_rd_data;

    always_ff @(posedge pos_clk or posedge pos_arst) begin
        if (pos_arst) begin
            state_q <= StIdle;
            op_q    <= OpScan;
            addr_q  <= '0;
            err_q   <= 1'b0;
            hold_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        err_d     = err_q;
        hold_d    = hold_q;
        data_d    = data_q;
        acc_clear = 1'b0;
        acc_en    = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    op_d      = op_e'(cmd_op);
                    addr_d    = '0;
                    err_d     = 1'b0;
                    hold_d    = 1'b0;
                    acc_clear = 1'b1;
                    case (op_e'(cmd_op))
                        OpScan, OpScanClear: state_d = StRd;
                        OpClear:             state_d = StWr;
                        default: begin
                            err_d   = 1'b1;
                            state_d = StRsp;
                        end
                    endcase
                end
            end
            StRd: begin
                if (!host_wr_en) begin
                    mem_rd_en = 1'b1;
                    state_d   = StChk;
                end
            end
            StChk: begin
                if (host_wr_en && host_wr_addr == addr_q) begin
                    // Word changed under us: drop the stale data and read again.
                    hold_d  = 1'b0;
                    state_d = StRd;
                end else if (op_q == OpScanClear && chk_data != '0 && host_wr_en) begin
                    hold_d = 1'b1;
                    data_d = chk_data;
                end else begin
                    hold_d    = 1'b0;
                    acc_en    = 1'b1;
                    mem_wr_en = (op_q == OpScanClear) && (chk_data != '0);
                    if (last) begin
                        state_d = StRsp;
                    end else begin
                        addr_d  = addr_q + ABITS'(1);
                        state_d = StRd;
                    end
                end
            end
            StWr: begin
                if (!host_wr_en) begin
                    mem_wr_en = 1'b1;
                    if (last) begin
                        state_d = StRsp;
                    end else begin
                        addr_d = addr_q + ABITS'(1);
                    end
                end
            end
            StRsp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    taint_scan_accum #(
        .ABITS (ABITS),
        .WIDTH (WIDTH)
    ) u_accum (
        .pos_clk  (pos_clk),
        .pos_arst (pos_arst),
        .clear    (acc_clear),
        .acc_en   (acc_en),
        .addr     (addr_q),
        .data     (chk_data),
        .count    (rsp_count),
        .first    (rsp_first),
        .found    (rsp_found),
        .mask     (rsp_mask)
    );

    assign cmd_ready   = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign rsp_valid   = (state_q == StRsp);
    assign rsp_err     = err_q;
    assign mem_rd_addr = addr_q;
    assign mem_wr_addr = addr_q;

endmodule

// File: tb/tb_taint_scan_ctrl.sv
// Self-checking bench for taint_scan_ctrl: table vectors, corner sequences and random sweeps
// checked against a whole-memory reference model.
module tb_taint_scan_ctrl;

    localparam int Limit = 400;

    logic       pos_clk = 1'b0;
    logic       pos_arst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic       host_wr_en = 1'b0;
    logic [5:0] host_wr_addr = '0;
    logic [7:0] host_wr_data = '0;
    logic       mem_rd_en;
    logic [5:0] mem_rd_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [5:0] mem_wr_addr;
    logic       busy;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [6:0] rsp_count;
    logic [5:0] rsp_first;
    logic       rsp_found;
    logic [7:0] rsp_mask;
    logic       rsp_err;

    taint_scan_ctrl #(
        .SIZE  (64),
        .ABITS (6),
        .WIDTH (8)
    ) dut (
        .pos_clk      (pos_clk),
        .pos_arst     (pos_arst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .host_wr_en   (host_wr_en),
        .host_wr_addr (host_wr_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .busy         (busy),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_count    (rsp_count),
        .rsp_first    (rsp_first),
        .rsp_found    (rsp_found),
        .rsp_mask     (rsp_mask),
        .rsp_err      (rsp_err)
    );

    always #5 pos_clk = ~pos_clk;

    // Taint memory model plus access monitors (monotonic counters, deltas taken by the test).
    logic [7:0] mem [64];
    int wr_total, rd_total, overlap_total;
    int wr_hits [64];

    always @(posedge pos_clk) begin
        if (mem_wr_en) begin
            mem[mem_wr_addr]     <= 8'h00;
            wr_total             <= wr_total + 1;
            wr_hits[mem_wr_addr] <= wr_hits[mem_wr_addr] + 1;
        end
        if (host_wr_en) mem[host_wr_addr] <= host_wr_data;
        if (mem_rd_en) begin
            mem_rd_data <= mem[mem_rd_addr];
            rd_total    <= rd_total + 1;
        end
        if ((mem_rd_en || mem_wr_en) && host_wr_en) overlap_total <= overlap_total + 1;
    end

    int errors = 0;
    int checks = 0;
    logic [7:0] ref_mem [64];
    int wr0, rd0, ov0;
    int hits0 [64];

    typedef struct {
        int         preset;
        logic [1:0] op;
        int         cnt;
        int         first;
        int         found;
        int         mask;
        int         err;
        int         lat;
        int         wr;
        int         rd;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_rsp(input string tag, input int cnt, input int first, input int mask,
                             input int err);
        check({tag, "_count"}, int'(rsp_count), cnt);
        check({tag, "_first"}, int'(rsp_first), first);
        check({tag, "_found"}, int'(rsp_found), (cnt != 0) ? 1 : 0);
        check({tag, "_mask"}, int'(rsp_mask), mask);
        check({tag, "_err"}, int'(rsp_err), err);
    endtask

    // Reference: whole-memory summary of ref_mem and the latency/write count with no stalls.
    task automatic model(input logic [1:0] op, output int cnt, output int first, output int mask,
                         output int err, output int lat, output int wr);
        cnt = 0; first = 0; mask = 0; err = 0; wr = 0;
        if (op == 2'b11) begin
            err = 1; lat = 0;
        end else if (op == 2'b01) begin
            lat = 64; wr = 64;
        end else begin
            lat = 128;
            for (int i = 0; i < 64; i++) begin
                if (ref_mem[i] != 8'h00) begin
                    if (cnt == 0) first = i;
                    cnt++;
                    mask = mask | int'(ref_mem[i]);
                    if (op == 2'b10) wr++;
                end
            end
        end
    endtask

    task automatic apply_model(input logic [1:0] op);
        if (op == 2'b01 || op == 2'b10) begin
            for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
        end
    endtask

    function automatic int mem_diff();
        int n = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    function automatic int distinct_writes();
        int n = 0;
        for (int i = 0; i < 64; i++) if (wr_hits[i] != hits0[i]) n++;
        return n;
    endfunction

    task automatic snap();
        wr0 = wr_total; rd0 = rd_total; ov0 = overlap_total;
        for (int i = 0; i < 64; i++) hits0[i] = wr_hits[i];
    endtask

    // 1: words 5/40 tainted, 2: all 0xFF, 3: random sparse taint.
    task automatic preload(input int preset);
        logic [7:0] d;
        for (int i = 0; i < 64; i++) begin
            if (preset == 1) d = (i == 5) ? 8'h01 : (i == 40) ? 8'h80 : 8'h00;
            else if (preset == 2) d = 8'hFF;
            else d = ($urandom_range(3) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            @(negedge pos_clk);
            host_wr_en = 1'b1; host_wr_addr = 6'(i); host_wr_data = d;
            ref_mem[i] = d;
        end
        @(negedge pos_clk);
        host_wr_en = 1'b0;
    endtask

    // Waits for rsp_valid, counting edges from the current one; optional host traffic.
    task automatic wait_rsp(input int alt, input int ev_c, input logic [5:0] ev_a,
                            input logic [7:0] ev_d, output int lat, output int hcnt);
        lat = -1; hcnt = 0;
        for (int c = 0; c <= Limit; c++) begin
            if (rsp_valid) begin
                lat = c;
                break;
            end
            host_wr_en = 1'b0;
            if (alt != 0 && (c % 2) == 0) begin
                host_wr_en = 1'b1;
                host_wr_addr = 6'($urandom_range(63));
                host_wr_data = ref_mem[host_wr_addr];
                hcnt++;
            end
            if (c == ev_c) begin
                host_wr_en = 1'b1; host_wr_addr = ev_a; host_wr_data = ev_d;
                ref_mem[ev_a] = ev_d;
            end
            @(posedge pos_clk); #1;
        end
        host_wr_en = 1'b0;
        if (lat < 0) begin
            check("rsp_timeout", lat, 0);
            pos_arst = 1'b1;
            @(negedge pos_clk);
            pos_arst = 1'b0;
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input int alt, input int ev_c,
                          input logic [5:0] ev_a, input logic [7:0] ev_d,
                          output int lat, output int hcnt);
        @(negedge pos_clk);
        cmd_op = op; cmd_valid = 1'b1;
        @(posedge pos_clk); #1;
        cmd_valid = 1'b0;
        wait_rsp(alt, ev_c, ev_a, ev_d, lat, hcnt);
    endtask

    task automatic finish_rsp(input string tag);
        @(negedge pos_clk);
        rsp_ready = 1'b1;
        @(posedge pos_clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, int'(rsp_valid), 0);
        check({tag, "_ready"}, int'(cmd_ready), 1);
    endtask

    // Runs a command, derives every expectation from the model, checks and retires it.
    task automatic run_check(input string tag, input logic [1:0] op, input int alt,
                             input int ev_c, input logic [5:0] ev_a, input logic [7:0] ev_d,
                             input int lat_extra, input int exp_rd);
        int lat, hc, cnt, first, mask, err, elat, ewr;
        snap();
        do_cmd(op, alt, ev_c, ev_a, ev_d, lat, hc);
        model(op, cnt, first, mask, err, elat, ewr);
        if (alt != 0)
            check({tag, "_lat_range"}, int'(lat >= elat + 1 && lat <= elat + 2 * hc), 1);
        else
            check({tag, "_lat"}, lat, elat + lat_extra);
        check_rsp(tag, cnt, first, mask, err);
        check({tag, "_writes"}, wr_total - wr0, ewr);
        check({tag, "_wr_addrs"}, distinct_writes(), ewr);
        if (exp_rd >= 0) check({tag, "_reads"}, rd_total - rd0, exp_rd);
        check({tag, "_overlap"}, overlap_total - ov0, 0);
        apply_model(op);
        check({tag, "_mem"}, mem_diff(), 0);
        finish_rsp(tag);
    endtask

    initial begin
        int lat, hc, cnt, first, mask, err, elat, ewr;

        vecs[0] = '{1, 2'b00, 2, 5, 1, 'h81, 0, 128, 0, 64};
        vecs[1] = '{1, 2'b10, 2, 5, 1, 'h81, 0, 128, 2, 64};
        vecs[2] = '{0, 2'b00, 0, 0, 0, 'h00, 0, 128, 0, 64};
        vecs[3] = '{2, 2'b01, 0, 0, 0, 'h00, 0, 64, 64, 0};
        vecs[4] = '{0, 2'b00, 0, 0, 0, 'h00, 0, 128, 0, 64};
        vecs[5] = '{0, 2'b11, 0, 0, 0, 'h00, 1, 0, 0, 0};

        repeat (2) @(posedge pos_clk);
        #1;
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_strobes", int'({mem_rd_en, mem_wr_en}), 0);
        check("rst_addrs", int'({mem_rd_addr, mem_wr_addr}), 0);
        check_rsp("rst", 0, 0, 0, 0);
        @(negedge pos_clk);
        pos_arst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].preset != 0) preload(vecs[i].preset);
            snap();
            do_cmd(vecs[i].op, 0, -1, 6'd0, 8'h00, lat, hc);
            check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("v%0d_count", i), int'(rsp_count), vecs[i].cnt);
            check($sformatf("v%0d_first", i), int'(rsp_first), vecs[i].first);
            check($sformatf("v%0d_found", i), int'(rsp_found), vecs[i].found);
            check($sformatf("v%0d_mask", i), int'(rsp_mask), vecs[i].mask);
            check($sformatf("v%0d_err", i), int'(rsp_err), vecs[i].err);
            check($sformatf("v%0d_writes", i), wr_total - wr0, vecs[i].wr);
            check($sformatf("v%0d_wr_addrs", i), distinct_writes(), vecs[i].wr);
            check($sformatf("v%0d_reads", i), rd_total - rd0, vecs[i].rd);
            apply_model(vecs[i].op);
            check($sformatf("v%0d_mem", i), mem_diff(), 0);
            finish_rsp($sformatf("v%0d", i));
        end

        // Host traffic on alternate cycles, starting in the first RD cycle.
        preload(1);
        run_check("alt", 2'b00, 1, -1, 6'd0, 8'h00, 0, -1);
        // Host write 0x04 to word 10 during its CHK cycle forces a re-read (+2 cycles).
        run_check("reread", 2'b00, 0, 21, 6'd10, 8'h04, 2, 65);
        // Host write elsewhere while SCAN_CLEAR is about to clear word 5 holds CHK one cycle.
        preload(1);
        run_check("hold", 2'b10, 0, 11, 6'd0, 8'h00, 1, 64);

        // Command held during RSP must wait for the edge after the rsp handshake.
        do_cmd(2'b11, 0, -1, 6'd0, 8'h00, lat, hc);
        check("held_rsvd_lat", lat, 0);
        @(negedge pos_clk);
        cmd_op = 2'b00; cmd_valid = 1'b1;
        repeat (3) @(posedge pos_clk);
        #1;
        check("held_not_ready", int'(cmd_ready), 0);
        check("held_rsp_stable", int'({rsp_valid, rsp_err, rsp_count}), 'h180);
        @(negedge pos_clk);
        rsp_ready = 1'b1;
        @(posedge pos_clk); #1;
        rsp_ready = 1'b0;
        check("held_hs_idle", int'({rsp_valid, busy, cmd_ready}), 1);
        @(posedge pos_clk); #1;
        cmd_valid = 1'b0;
        check("held_accept", int'(busy), 1);
        wait_rsp(0, -1, 6'd0, 8'h00, lat, hc);
        model(2'b00, cnt, first, mask, err, elat, ewr);
        check("held_scan_lat", lat, elat);
        check_rsp("held_scan", cnt, first, mask, err);
        finish_rsp("held_scan");

        // Reset pulsed mid-sweep, after word 5 has already been counted.
        preload(1);
        @(negedge pos_clk);
        cmd_op = 2'b00; cmd_valid = 1'b1;
        @(posedge pos_clk); #1;
        cmd_valid = 1'b0;
        repeat (30) @(posedge pos_clk);
        #2 pos_arst = 1'b1;
        #1;
        check("mid_rst_state", int'({busy, rsp_valid, cmd_ready}), 1);
        check("mid_rst_strobe", int'({mem_rd_en, mem_wr_en}), 0);
        check("mid_rst_count", int'(rsp_count), 0);
        @(negedge pos_clk);
        pos_arst = 1'b0;
        run_check("post_rst", 2'b00, 0, -1, 6'd0, 8'h00, 0, 64);

        for (int i = 0; i < 6; i++) begin
            preload(3);
            run_check($sformatf("rnd%0d", i), 2'($urandom_range(3)), 0, -1, 6'd0, 8'h00, 0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
